// File: rtl/ud_counter_chain.sv
// ud_counter_chain: cascade of DIGITS up/down counter digits of modulus MOD,
// counting as one multi-digit value. Supports parallel load with per-digit
// clamping, wrap or saturate at the range limits, and a registered wrap pulse.
module ud_counter_chain #(
  parameter int DIGITS   = 4,
  parameter int DW       = 4,
  parameter int MOD      = 10,
  parameter int SAT_MODE = 0
) (
  input  logic                 inter_clk,
  input  logic                 clr,
  input  logic                 cnt,
  input  logic                 ld,
  input  logic                 up,
  input  logic                 sat,
  input  logic [DIGITS*DW-1:0] ld_val,
  output logic [DIGITS*DW-1:0] c,
  output logic                 tc,
  output logic                 wrap_p
);

  localparam logic [DW-1:0] MAXD = DW'(MOD - 1);
  localparam logic [DW:0]   MODW = (DW + 1)'(MOD);

  logic [DIGITS-1:0][DW-1:0] c_q, c_d;
  logic                      wrap_q, wrap_d;
  logic [DIGITS-1:0]         lo_max, lo_zero;
  logic                      all_max, all_zero;
  logic                      sat_eff;

  // SAT_MODE flips the meaning of the sat input.
  assign sat_eff = sat ^ (SAT_MODE != 0);

  // Per-digit carry/borrow enables: lo_max[i] / lo_zero[i] mean every digit
  // below i sits at MOD-1 / 0, so digit i steps on this count.
  always_comb begin
    lo_max  = '0;
    lo_zero = '0;
    lo_max[0]  = 1'b1;
    lo_zero[0] = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      lo_max[i]  = lo_max[i-1]  & (c_q[i-1] == MAXD);
      lo_zero[i] = lo_zero[i-1] & (c_q[i-1] == '0);
    end
    all_max  = lo_max[DIGITS-1]  & (c_q[DIGITS-1] == MAXD);
    all_zero = lo_zero[DIGITS-1] & (c_q[DIGITS-1] == '0);
  end

  assign tc = up ? all_max : all_zero;

  // Next-state: load (with clamping) beats count beats hold. At the limit the
  // plain carry rules already produce the wrapped value, so wrap mode needs no
  // special case; saturate mode simply suppresses the count.
  always_comb begin
    c_d    = c_q;
    wrap_d = 1'b0;
    if (ld) begin
      for (int i = 0; i < DIGITS; i++) begin
        if ({1'b0, ld_val[i*DW +: DW]} >= MODW)
          c_d[i] = MAXD;
        else
          c_d[i] = ld_val[i*DW +: DW];
      end
    end else if (cnt && !(tc && sat_eff)) begin
      wrap_d = tc;
      for (int i = 0; i < DIGITS; i++) begin
        if (up && lo_max[i])
          c_d[i] = (c_q[i] == MAXD) ? '0 : c_q[i] + DW'(1);
        else if (!up && lo_zero[i])
          c_d[i] = (c_q[i] == '0) ? MAXD : c_q[i] - DW'(1);
      end
    end
  end

  // Count and wrap-pulse registers, cleared asynchronously by clr.
  always_ff @(posedge inter_clk or posedge clr) begin
    if (clr) begin
      c_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      c_q    <= c_d;
      wrap_q <= wrap_d;
    end
  end

  assign c      = c_q;
  assign wrap_p = wrap_q;

endmodule
